serial_adder_ctrl: RTL and testbench

Multi-cycle sequencer that adds two WIDTH-bit operands plus carry-in using a single 2-bit ripple-carry slice, two bits per clock, LSB chunk first. Sits between a requester (valid/ready input handshake) and a consumer (valid/ready output handshake). Trades area for latency: one shared 2-bit slice replaces a full-width adder.

---
 rtl/serial_adder_ctrl.sv | 152 +++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - serial adder sequencer, two sum bits per clock
//
// Adds two WIDTH-bit operands plus carry-in with one shared 2-bit ripple
// slice, LSB chunk first, WIDTH/2 RUN cycles per operation.
// Optional feature macro: SERIAL_ADDER_OVF_EN (adds the ovf output).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   requester presents a, b, c_in
//   in_ready   operands accepted this cycle if in_valid (IDLE only)
//   a, b       operands, sampled on acceptance
//   c_in       carry-in, sampled on acceptance
//   out_valid  sum/c_out valid (DONE only)
//   out_ready  consumer takes the result
//   sum        registered (a+b+c_in) mod 2^WIDTH
//   c_out      registered carry out of bit WIDTH-1
//   busy       RUN or DONE
//   ovf        signed overflow (SERIAL_ADDER_OVF_EN only)

`timescale 1ns/1ps

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int HALF  = WIDTH / 2;
  localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(HALF - 1);

  generate
    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
      $error("serial_adder_ctrl: WIDTH must be even and >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   idx_q;
  logic [CNT_W-1:0]   idx_d;
  logic               carry_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   sum_q;
  logic               c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
  logic               ovf_q;
`endif

  // Shared 2-bit slice working on chunk idx_q.
  logic [1:0] a_chunk;
  logic [1:0] b_chunk;
  logic [2:0] chunk_sum;
  logic       mid_carry;

  assign a_chunk   = a_q[{idx_q, 1'b0} +: 2];
  assign b_chunk   = b_q[{idx_q, 1'b0} +: 2];
  assign chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {2'b00, carry_q};
  // Carry from the low bit into the high bit of the chunk; on the final
  // chunk this is the carry into the MSB, used for signed overflow.
  assign mid_carry = (a_chunk[0] & b_chunk[0]) | (carry_q & (a_chunk[0] ^ b_chunk[0]));
  assign idx_d     = idx_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= c_in;
            idx_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          sum_q[{idx_q, 1'b0} +: 2] <= chunk_sum[1:0];
          carry_q <= chunk_sum[2];
          if (idx_q == LAST_IDX) begin
            c_out_q <= chunk_sum[2];
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= mid_carry ^ chunk_sum[2];
`endif
            idx_q   <= '0;
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_d;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Handshake and status outputs decode straight from the state register.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign sum       = sum_q;
  assign c_out     = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf       = ovf_q;
`else
  // mid_carry only feeds the overflow flag.
  logic unused_mid_carry;
  assign unused_mid_carry = mid_carry;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl

`timescale 1ns/1ps

module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             busy;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Scoreboard entries: {ovf, c_out, sum}
  logic [WIDTH+1:0] sb_q[$];

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .busy      (busy)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic ci);
    logic [WIDTH:0] t;
    logic           v;
    t = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
    v = (x[WIDTH-1] == y[WIDTH-1]) && (t[WIDTH-1] != x[WIDTH-1]);
    return {v, t};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c_in = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (sum !== 8'h00) begin errors++; $display("FAIL reset_sum: got %h want 00", sum); end
    checks++; if (c_out !== 1'b0) begin errors++; $display("FAIL reset_c_out: got %b want 0", c_out); end
`ifdef SERIAL_ADDER_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
  endtask

  task automatic test_basic;
    logic [WIDTH-1:0] va[8];
    logic [WIDTH-1:0] vb[8];
    logic             vc[8];
    logic [WIDTH+1:0] exp;
    int               n;
    va = '{8'h00, 8'hFF, 8'h5A, 8'h7F, 8'h80, 8'hFF, 8'h00, 8'h00};
    vb = '{8'h00, 8'h01, 8'h25, 8'h01, 8'h80, 8'hFF, 8'h00, 8'h00};
    vc = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0};
    for (int i = 6; i < 8; i++) begin
      va[i] = WIDTH'($urandom);
      vb[i] = WIDTH'($urandom);
      vc[i] = 1'($urandom);
    end
    for (int i = 0; i < 8; i++) begin
      a = va[i]; b = vb[i]; c_in = vc[i]; in_valid = 1'b1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic%0d_in_ready: got %b want 1", i, in_ready); end
      sb_q.push_back(model(va[i], vb[i], vc[i]));
      tick();
      in_valid = 1'b0;
      checks++; if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++; $display("FAIL basic%0d_run_state: busy=%b in_ready=%b out_valid=%b want 1/0/0", i, busy, in_ready, out_valid);
      end
      wait_out_valid(n);
      checks++; if (n != 4) begin errors++; $display("FAIL basic%0d_latency: got %0d want 4", i, n); end
      exp = sb_q.pop_front();
      checks++; if (sum !== exp[WIDTH-1:0]) begin errors++; $display("FAIL basic%0d_sum: got %h want %h", i, sum, exp[WIDTH-1:0]); end
      checks++; if (c_out !== exp[WIDTH]) begin errors++; $display("FAIL basic%0d_c_out: got %b want %b", i, c_out, exp[WIDTH]); end
`ifdef SERIAL_ADDER_OVF_EN
      checks++; if (ovf !== exp[WIDTH+1]) begin errors++; $display("FAIL basic%0d_ovf: got %b want %b", i, ovf, exp[WIDTH+1]); end
`endif
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
        errors++; $display("FAIL basic%0d_idle_return: out_valid=%b in_ready=%b busy=%b want 0/1/0", i, out_valid, in_ready, busy);
      end
      checks++; if (sum !== exp[WIDTH-1:0]) begin errors++; $display("FAIL basic%0d_sum_hold: got %h want %h", i, sum, exp[WIDTH-1:0]); end
    end
  endtask

  task automatic test_backpressure;
    logic [WIDTH+1:0] exp;
    int               n;
    bit               ok;
    a = 8'h33; b = 8'h44; c_in = 1'b0; in_valid = 1'b1;
    sb_q.push_back(model(8'h33, 8'h44, 1'b0));
    tick();
    // New operands held on the bus while busy must be ignored.
    a = 8'h11; b = 8'h22; c_in = 1'b1;
    wait_out_valid(n);
    exp = sb_q.pop_front();
    checks++; if (sum !== exp[WIDTH-1:0] || c_out !== exp[WIDTH]) begin
      errors++; $display("FAIL bp_first_result: got %b/%h want %b/%h", c_out, sum, exp[WIDTH], exp[WIDTH-1:0]);
    end
    out_ready = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sum !== exp[WIDTH-1:0] || c_out !== exp[WIDTH] || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
    end
    checks++; if (!ok) begin errors++; $display("FAIL bp_hold: sum=%h c_out=%b in_ready=%b out_valid=%b want %h/%b/0/1", sum, c_out, in_ready, out_valid, exp[WIDTH-1:0], exp[WIDTH]); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    sb_q.push_back(model(8'h11, 8'h22, 1'b1));
    tick();
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_accept_next: busy=%b in_ready=%b want 1/0", busy, in_ready);
    end
    wait_out_valid(n);
    exp = sb_q.pop_front();
    checks++; if (sum !== exp[WIDTH-1:0] || c_out !== exp[WIDTH]) begin
      errors++; $display("FAIL bp_second_result: got %b/%h want %b/%h", c_out, sum, exp[WIDTH], exp[WIDTH-1:0]);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    bit seen;
    a = 8'hAA; b = 8'h55; c_in = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_state: in_ready=%b busy=%b out_valid=%b want 1/0/0", in_ready, busy, out_valid);
    end
    checks++; if (sum !== 8'h00 || c_out !== 1'b0) begin
      errors++; $display("FAIL midrst_clear: sum=%h c_out=%b want 00/0", sum, c_out);
    end
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL midrst_no_output: out_valid seen=1 want 0"); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_back_to_back;
    logic [WIDTH-1:0] va[3];
    logic [WIDTH-1:0] vb[3];
    logic             vc[3];
    int               acc[3];
    logic [WIDTH+1:0] exp;
    int               issued;
    int               results;
    int               budget;
    bit               adv;
    va = '{8'h12, 8'hF0, 8'h7F};
    vb = '{8'h34, 8'h0F, 8'h7F};
    vc = '{1'b0,  1'b1,  1'b1};
    issued = 0; results = 0; budget = 0;
    a = va[0]; b = vb[0]; c_in = vc[0]; in_valid = 1'b1; out_ready = 1'b1;
    while (results < 3 && budget < 60) begin
      adv = 1'b0;
      if (out_valid === 1'b1) begin
        exp = sb_q.pop_front();
        checks++; if (sum !== exp[WIDTH-1:0] || c_out !== exp[WIDTH]) begin
          errors++; $display("FAIL b2b%0d_result: got %b/%h want %b/%h", results, c_out, sum, exp[WIDTH], exp[WIDTH-1:0]);
        end
        results++;
      end
      if (in_valid && in_ready === 1'b1) begin
        acc[issued] = cyc;
        sb_q.push_back(model(va[issued], vb[issued], vc[issued]));
        issued++;
        adv = 1'b1;
      end
      tick();
      budget++;
      if (adv) begin
        if (issued < 3) begin
          a = va[issued]; b = vb[issued]; c_in = vc[issued];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++; if (results != 3) begin errors++; $display("FAIL b2b_count: got %0d results want 3", results); end
    checks++; if (issued != 3 || acc[1] - acc[0] != 6 || acc[2] - acc[1] != 6) begin
      errors++; $display("FAIL b2b_spacing: issued=%0d gaps=%0d,%0d want 3 with 6,6", issued, acc[1] - acc[0], acc[2] - acc[1]);
    end
    sb_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
